// File: rtl/qed_dup_ctrl_pkg.sv
// Shared QED definitions: mode FSM encoding, nop opcode and occupancy command payload.
package qed_dup_ctrl_pkg;

    localparam int unsigned OCC_W = 6;

    localparam logic [1:0] ST_ORIG  = 2'd0;
    localparam logic [1:0] ST_DUP   = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    localparam logic [6:0] NOP_OPCODE = 7'b1111111;

    typedef struct packed {
        logic ins;
        logic del;
    } occ_cmd_t;

    function automatic logic is_nop(input logic [31:0] instr);
        return instr[6:0] == NOP_OPCODE;
    endfunction

endpackage

// File: rtl/qed_occ_counter.sv
// Saturating up/down counter mirroring the QED instruction-cache occupancy.
module qed_occ_counter
    import qed_dup_ctrl_pkg::*;
#(
    parameter int unsigned QCAP = 63
) (
    input  logic             clk,
    input  logic             rst,
    input  occ_cmd_t         cmd_i,
    output logic [OCC_W-1:0] occ_o
);

    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    // Bounds are rechecked here so the counter cannot wrap even if a caller skips gating.
    always_comb begin
        occ_d = occ_q;
        if (cmd_i.ins && (occ_q != OCC_W'(QCAP))) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (cmd_i.del && (occ_q != '0)) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occ_o = occ_q;

endmodule

// File: rtl/qed_dup_ctrl.sv
// QED mode controller: alternates original and duplicate execution phases and
// flags a check point once every queued instruction has been replayed.
module qed_dup_ctrl
    import qed_dup_ctrl_pkg::*;
#(
    parameter int unsigned ORIG_LIMIT = 32,
    parameter int unsigned QCAP       = 63
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IF_stall,
    input  logic [31:0]      ifu_qed_instruction,
    input  logic             force_dup,
    output logic             exec_dup,
    output logic [OCC_W-1:0] qed_occupancy,
    output logic             qed_check_point
);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             exec_dup_q;
    logic             check_q;
    logic [OCC_W-1:0] occ_q;
    logic             nop_c;
    occ_cmd_t         cmd_c;

    // Insert/delete qualifiers use the registered mode, never the next one.
    assign nop_c   = is_nop(ifu_qed_instruction);
    assign cmd_c.ins = ~exec_dup_q & ~nop_c & ~IF_stall & (occ_q != OCC_W'(QCAP));
    assign cmd_c.del = exec_dup_q & (occ_q != '0) & ~IF_stall;

    qed_occ_counter #(
        .QCAP (QCAP)
    ) u_occ (
        .clk   (clk),
        .rst   (rst),
        .cmd_i (cmd_c),
        .occ_o (occ_q)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ORIG: begin
                if ((occ_q >= OCC_W'(ORIG_LIMIT)) || (force_dup && (occ_q != '0))) begin
                    state_d = ST_DUP;
                end
            end
            ST_DUP: begin
                if (!IF_stall && (occ_q == '0)) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: state_d = ST_ORIG;
            default:  state_d = ST_ORIG;
        endcase
    end

    // Mode outputs are registered alongside the state so they track it exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_ORIG;
            exec_dup_q <= 1'b0;
            check_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            exec_dup_q <= (state_d == ST_DUP);
            check_q    <= (state_d == ST_CHECK);
        end
    end

    assign exec_dup        = exec_dup_q;
    assign qed_check_point = check_q;
    assign qed_occupancy   = occ_q;

endmodule

// File: tb/tb_qed_dup_ctrl.sv
// Scoreboard bench for qed_dup_ctrl: directed phases on a default instance and an ORIG_LIMIT=63 instance.
module tb_qed_dup_ctrl;

    localparam logic [31:0] INSTR_OP  = 32'h0000_0013;
    localparam logic [31:0] INSTR_NOP = 32'h0000_007F;

    logic        clk = 1'b0;
    logic        rst_a = 1'b0;
    logic        rst_b = 1'b0;
    logic        if_stall = 1'b1;
    logic [31:0] instr = INSTR_NOP;
    logic        force_dup = 1'b0;
    logic        dup_a, cp_a, dup_b, cp_b;
    logic [5:0]  occ_a, occ_b;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit       sel;
        bit       dup;
        bit [5:0] occ;
        bit       cp;
        int       tag;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    qed_dup_ctrl #(.ORIG_LIMIT(32), .QCAP(63)) u_dut_a (
        .clk                 (clk),
        .rst                 (rst_a),
        .IF_stall            (if_stall),
        .ifu_qed_instruction (instr),
        .force_dup           (force_dup),
        .exec_dup            (dup_a),
        .qed_occupancy       (occ_a),
        .qed_check_point     (cp_a)
    );

    qed_dup_ctrl #(.ORIG_LIMIT(63), .QCAP(63)) u_dut_b (
        .clk                 (clk),
        .rst                 (rst_b),
        .IF_stall            (if_stall),
        .ifu_qed_instruction (instr),
        .force_dup           (force_dup),
        .exec_dup            (dup_b),
        .qed_occupancy       (occ_b),
        .qed_check_point     (cp_b)
    );

    task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s step=%0d actual=%0d required=%0d", nm, tag, act, req);
        end
    endtask

    task automatic push_exp(input bit sel, input bit dup, input int occ, input bit cp, input int tag);
        exp_t e;
        e.sel = sel;
        e.dup = dup;
        e.occ = 6'(occ);
        e.cp  = cp;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // One clock of stimulus; the expectation describes outputs after the coming rising edge.
    task automatic step(input bit sel, input bit stall, input bit fetch, input bit frc,
                        input bit dup, input int occ, input bit cp, input int tag);
        @(negedge clk);
        if_stall  = stall;
        instr     = fetch ? INSTR_OP : INSTR_NOP;
        force_dup = frc;
        push_exp(sel, dup, occ, cp, tag);
    endtask

    // Monitor: one expectation is consumed per rising edge once stimulus has queued one.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.sel == 1'b0) begin
                    chk("a_exec_dup", e.tag, 32'(dup_a), 32'(e.dup));
                    chk("a_occupancy", e.tag, 32'(occ_a), 32'(e.occ));
                    chk("a_check_point", e.tag, 32'(cp_a), 32'(e.cp));
                end else begin
                    chk("b_exec_dup", e.tag, 32'(dup_b), 32'(e.dup));
                    chk("b_occupancy", e.tag, 32'(occ_b), 32'(e.occ));
                    chk("b_check_point", e.tag, 32'(cp_b), 32'(e.cp));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog step=0 actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_exec_dup", 0, 32'(dup_a), 32'd0);
        chk("reset_occupancy", 0, 32'(occ_a), 32'd0);
        chk("reset_check_point", 0, 32'(cp_a), 32'd0);

        // Release: first active cycle must be quiet.
        @(negedge clk);
        rst_a = 1'b0;
        step(0, 0, 0, 0, 0, 0, 0, 1);

        // Fill to the limit, switch to duplicate, drain, one check pulse.
        for (int i = 1; i <= 32; i++) step(0, 0, 1, 0, 0, i, 0, 100 + i);
        step(0, 0, 0, 0, 1, 32, 0, 133);
        for (int j = 1; j <= 32; j++) step(0, 0, 0, 0, 1, 32 - j, 0, 140 + j);
        step(0, 0, 0, 0, 0, 0, 1, 173);
        step(0, 0, 0, 0, 0, 0, 0, 174);

        // force_dup at zero occupancy is ignored; later force switches early.
        step(0, 0, 0, 1, 0, 0, 0, 200);
        step(0, 0, 0, 1, 0, 0, 0, 201);
        for (int i = 1; i <= 10; i++) step(0, 0, 1, 0, 0, i, 0, 210 + i);
        step(0, 0, 0, 1, 1, 10, 0, 221);
        for (int j = 1; j <= 10; j++) step(0, 0, 0, (j < 3), 1, 10 - j, 0, 230 + j);
        step(0, 0, 0, 1, 0, 0, 1, 241);
        // Fetch during the check cycle lands in the cache.
        step(0, 0, 1, 1, 0, 1, 0, 242);
        step(0, 0, 0, 0, 0, 1, 0, 243);

        // Stalls and nops in original mode, stalls in duplicate mode.
        step(0, 1, 1, 0, 0, 1, 0, 300);
        step(0, 0, 0, 0, 0, 1, 0, 301);
        step(0, 0, 1, 0, 0, 2, 0, 302);
        step(0, 1, 0, 0, 0, 2, 0, 303);
        step(0, 0, 1, 0, 0, 3, 0, 304);
        step(0, 0, 0, 1, 1, 3, 0, 305);
        step(0, 0, 0, 0, 1, 2, 0, 306);
        step(0, 1, 0, 0, 1, 2, 0, 307);
        step(0, 1, 1, 0, 1, 2, 0, 308);
        step(0, 0, 0, 0, 1, 1, 0, 309);
        step(0, 0, 0, 0, 1, 0, 0, 310);
        step(0, 1, 0, 0, 1, 0, 0, 311);
        step(0, 0, 0, 0, 0, 0, 1, 312);
        step(0, 0, 0, 0, 0, 0, 0, 313);

        // Asynchronous reset in the middle of a duplicate phase at occupancy 17.
        for (int i = 1; i <= 17; i++) step(0, 0, 1, 0, 0, i, 0, 400 + i);
        step(0, 0, 0, 1, 1, 17, 0, 418);
        @(posedge clk);
        #3;
        rst_a = 1'b1;
        #1;
        chk("async_exec_dup", 419, 32'(dup_a), 32'd0);
        chk("async_occupancy", 419, 32'(occ_a), 32'd0);
        chk("async_check_point", 419, 32'(cp_a), 32'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0, 420 + i);
        @(negedge clk);
        rst_a     = 1'b0;
        if_stall  = 1'b0;
        instr     = INSTR_NOP;
        force_dup = 1'b0;
        push_exp(0, 0, 0, 0, 430);
        step(0, 0, 0, 0, 0, 0, 0, 431);

        // Limit 63 instance: 70 fetches saturate at 63, then duplicate mode drains.
        step(0, 0, 0, 0, 0, 0, 0, 499);
        @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b0;
        push_exp(1, 0, 0, 0, 500);
        for (int i = 1; i <= 63; i++) step(1, 0, 1, 0, 0, i, 0, 500 + i);
        step(1, 0, 1, 0, 1, 63, 0, 564);
        for (int k = 1; k <= 6; k++) step(1, 0, 1, 0, 1, 63 - k, 0, 564 + k);

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 999, 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/qed_dup_ctrl.md
QED_DUP_CTRL -- requirements
Module: qed_dup_ctrl

Interface
REQ-001 SHALL have parameter ORIG_LIMIT, default 32, range 1..63: original-mode instruction count that triggers duplicate mode.
REQ-002 SHALL have parameter QCAP, default 63: usable QED instruction-cache depth (6-bit tail, one slot reserved).
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port IF_stall, input, 1: fetch stall; no insert or delete in a stalled cycle.
REQ-006 SHALL have port ifu_qed_instruction, input, 32: fetched instruction; nop when bits [6:0] = 7'b1111111.
REQ-007 SHALL have port force_dup, input, 1: request an early switch to duplicate mode.
REQ-008 SHALL have port exec_dup, output, 1: registered mode select driven to the QED instruction cache.
REQ-009 SHALL have port qed_occupancy, output, 6: mirrored cache occupancy.
REQ-010 SHALL have port qed_check_point, output, 1: one-cycle pulse when a duplicate phase completes and architectural state is comparable.

Function
REQ-011 SHALL define ins = ~exec_dup & ~nop & ~IF_stall & (occupancy != QCAP), using the current registered exec_dup.
REQ-012 SHALL define del = exec_dup & (occupancy != 0) & ~IF_stall.
REQ-013 SHALL increment occupancy by 1 on ins, decrement it by 1 on del, and hold it otherwise; ins and del are mutually exclusive by construction.
REQ-014 SHALL never wrap occupancy: it saturates at QCAP because of the ins gate and at 0 because of the del gate.
REQ-015 SHALL implement an FSM with three states: ORIG (exec_dup=0), DUP (exec_dup=1), CHECK (exec_dup=0, qed_check_point=1).
REQ-016 SHALL transition ORIG->DUP when registered occupancy >= ORIG_LIMIT, or when force_dup=1 and occupancy != 0.
REQ-017 SHALL ignore force_dup in ORIG when occupancy = 0, and SHALL ignore it in DUP and CHECK.
REQ-018 SHALL transition DUP->CHECK when registered occupancy = 0; an IF_stall in DUP holds the state.
REQ-019 SHALL transition CHECK->ORIG unconditionally after exactly one cycle.
REQ-020 SHALL allow inserts in the CHECK cycle (exec_dup=0), which increment occupancy.
REQ-021 SHALL drive exec_dup and qed_check_point from state registers only, with no combinational path from inputs.
REQ-022 SHALL make the mode change visible one cycle after the qualifying condition: exec_dup rises on the first edge where the registered occupancy reaches ORIG_LIMIT.

Reset
REQ-023 SHALL on rst=1, at any time and regardless of clk, set state to ORIG, occupancy to 0, exec_dup to 0 and qed_check_point to 0.
REQ-024 SHALL, when reset is asserted mid-DUP, abandon the phase with no CHECK pulse; the cache's own reset clears its contents consistently.
REQ-025 SHALL release reset with no pulse on any output in the first active cycle.

Structure
REQ-026 SHALL place the FSM state encoding (ORIG=2'd0, DUP=2'd1, CHECK=2'd2) and the nop opcode constant 7'b1111111 in the shared qed header.
REQ-027 SHALL be a single module; the occupancy counter MAY be a sub-module named qed_occ_counter (up/down counter with saturation).

Verification
REQ-028 SHALL cover: 32 unstalled non-nop fetches from reset -> occupancy 32, exec_dup=1 next cycle; then 32 unstalled cycles -> occupancy 0, one qed_check_point pulse, then exec_dup=0.
REQ-029 SHALL cover: 10 fetches, then force_dup=1 -> exec_dup=1 next cycle; 10 deletes -> CHECK pulse; force_dup=1 at occupancy 0 -> no state change.
REQ-030 SHALL cover: nop fetches and IF_stall=1 cycles interleaved in ORIG -> occupancy unchanged on those cycles; IF_stall=1 in DUP -> occupancy and state held.
REQ-031 SHALL cover: ORIG_LIMIT=63, 70 fetches -> occupancy saturates at 63, no wrap, DUP entered.
REQ-032 SHALL cover: rst asserted asynchronously mid-DUP at occupancy 17 -> outputs 0/0/0 immediately, no qed_check_point pulse.
REQ-033 SHALL cover: a non-nop fetch during the CHECK cycle -> occupancy 1 in the following ORIG cycle.
